// File: rtl/redirect_ctrl.sv
// redirect_ctrl: sequences PC-source select, IF/ID write enables and IF/ID flushes
// for taken branches, jumps, load-use and memory stalls. Perf counters: REDIRECT_PERF_EN.
module redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             branch,
  input  logic [1:0]       jump,
  input  logic             load_use,
  input  logic             mem_stall,
  output logic [1:0]       pc_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_PEND} state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] pc_sel_q, pc_sel_d;
  logic [1:0] pend_sel_q, pend_sel_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       flush_q, flush_d;
  logic       redir;
  logic [1:0] tgt;
  logic       fe_enable;

  // Branch outranks any jump; jump=11 is not a redirect.
  always_comb begin
    redir = branch | (jump == 2'b01) | (jump == 2'b10);
    tgt   = (!branch && (jump == 2'b10)) ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d    = state_q;
    pc_sel_d   = 2'b00;
    flush_d    = flush_q;
    fcnt_d     = fcnt_q;
    pend_sel_d = pend_sel_q;
    case (state_q)
      ST_RUN: begin
        flush_d = 1'b0;
        if (redir && !mem_stall) begin
          pc_sel_d = tgt;
          flush_d  = 1'b1;
          fcnt_d   = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end else if (redir) begin
          pend_sel_d = tgt;
          state_d    = ST_PEND;
        end
      end
      // Redirect inputs here come from instructions being squashed.
      ST_FLUSH: begin
        if (!mem_stall) begin
          if (fcnt_q == 2'd0) begin
            flush_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
      end
      ST_PEND: begin
        if (!mem_stall) begin
          pc_sel_d = pend_sel_q;
          flush_d  = 1'b1;
          fcnt_d   = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      pc_sel_q   <= 2'b00;
      pend_sel_q <= 2'b00;
      fcnt_q     <= 2'd0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_sel_q   <= pc_sel_d;
      pend_sel_q <= pend_sel_d;
      fcnt_q     <= fcnt_d;
      flush_q    <= flush_d;
    end
  end

  // The load-use instruction is being squashed while ID_Flush is high.
  assign fe_enable   = ~mem_stall & ~(load_use & ~flush_q);
  assign pc_write    = fe_enable;
  assign if_id_write = fe_enable;
  assign pc_sel      = pc_sel_q;
  assign IF_Flush    = flush_q;
  assign ID_Flush    = flush_q;

`ifdef REDIRECT_PERF_EN
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH) && !(&redirect_cnt_q))
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    if (!fe_enable && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Randomized self-checking bench for redirect_ctrl against a credit-based reference model.
module tb_redirect_ctrl;
  localparam int FC = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          branch = 1'b0;
  logic [1:0]    jump = 2'b00;
  logic          load_use = 1'b0;
  logic          mem_stall = 1'b0;
  logic [1:0]    pc_sel;
  logic          pc_write;
  logic          if_id_write;
  logic          IF_Flush;
  logic          ID_Flush;
  logic [CW-1:0] redirect_cnt;
  logic [CW-1:0] stall_cnt;

  redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .branch(branch), .jump(jump),
    .load_use(load_use), .mem_stall(mem_stall), .pc_sel(pc_sel),
    .pc_write(pc_write), .if_id_write(if_id_write), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: flush credits still owed, pending target, expected pc_sel.
  int m_flush_left;
  int m_pend;
  int m_sel;
  int m_redir_cnt;
  int m_stall_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int target_of(input logic b, input logic [1:0] j);
    if (b) return 1;
    if (j == 2'b01) return 1;
    if (j == 2'b10) return 2;
    return 0;
  endfunction

  function automatic logic exp_enable();
    return !mem_stall && !(load_use && (m_flush_left == 0));
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_pend       = 0;
    m_sel        = 0;
    m_redir_cnt  = 0;
    m_stall_cnt  = 0;
  endtask

  task automatic model_accept(input int t);
    m_sel        = t;
    m_flush_left = FC;
    m_redir_cnt++;
  endtask

  task automatic model_step();
    int t;
    t = target_of(branch, jump);
    if (!exp_enable() && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
    m_sel = 0;
    if (m_flush_left > 0) begin
      if (!mem_stall) m_flush_left--;
    end else if (m_pend != 0) begin
      if (!mem_stall) begin
        model_accept(m_pend);
        m_pend = 0;
      end
    end else if (t != 0) begin
      if (!mem_stall) model_accept(t);
      else m_pend = t;
    end
  endtask

  task automatic check_outputs();
    logic en;
    en = exp_enable();
    chk("pc_sel", 32'(pc_sel), 32'(m_sel));
    chk("pc_write", 32'(pc_write), 32'(en));
    chk("if_id_write", 32'(if_id_write), 32'(en));
    chk("IF_Flush", 32'(IF_Flush), 32'(m_flush_left > 0));
    chk("ID_Flush", 32'(ID_Flush), 32'(m_flush_left > 0));
`ifdef REDIRECT_PERF_EN
    chk("redirect_cnt", 32'(redirect_cnt), 32'(m_redir_cnt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
`else
    chk("redirect_cnt", 32'(redirect_cnt), 32'd0);
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
  endtask

  task automatic do_cycle(input logic b, input logic [1:0] j, input logic lu, input logic ms);
    @(posedge clk);
    model_step();
    #1;
    branch    = b;
    jump      = j;
    load_use  = lu;
    mem_stall = ms;
    @(negedge clk);
    check_outputs();
    $display("cyc t=%0t b=%0b j=%0b lu=%0b ms=%0b -> pc_sel=%0b pcw=%0b flush=%0b/%0b rcnt=%0d scnt=%0d",
             $time, b, j, lu, ms, pc_sel, pc_write, IF_Flush, ID_Flush, redirect_cnt, stall_cnt);
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks outputs clear at once.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_IF_Flush", 32'(IF_Flush), 32'd0);
    chk("rst_ID_Flush", 32'(ID_Flush), 32'd0);
    chk("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    $display("reset asserted t=%0t pc_sel=%0b flush=%0b/%0b", $time, pc_sel, IF_Flush, ID_Flush);
    model_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    branch    = 1'b0;
    jump      = 2'b00;
    load_use  = 1'b0;
    mem_stall = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  // Directed prefix: {branch, jump[1:0], load_use, mem_stall}
  logic [4:0] dir_q[$] = '{
    5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b01100, 5'b00000, 5'b00010, 5'b10000, 5'b00010, 5'b00010, 5'b00000, 5'b00000,
    5'b01001, 5'b00001, 5'b00101, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b10000, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b00100, 5'b00000
  };

  initial begin
    logic [4:0] v;
    logic       ms;
    model_reset();
    #1;
    chk("reset_pc_sel", 32'(pc_sel), 32'd0);
    chk("reset_flush", 32'(IF_Flush | ID_Flush), 32'd0);
    chk("reset_redirect_cnt", 32'(redirect_cnt), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs();

    for (int i = 0; i < dir_q.size(); i++) begin
      v = dir_q[i];
      do_cycle(v[4], v[3:2], v[1], v[0]);
    end

    // Reset while a flush is in progress.
    do_cycle(1'b1, 2'b00, 1'b0, 1'b0);
    do_cycle(1'b0, 2'b00, 1'b0, 1'b0);
    async_reset();

    ms = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic       b;
      logic [1:0] j;
      logic       lu;
      ms = ($urandom_range(0, 99) < (ms ? 60 : 20));
      b  = ($urandom_range(0, 99) < 12);
      j  = ($urandom_range(0, 99) < 70) ? 2'b00 : 2'($urandom_range(0, 3));
      lu = ($urandom_range(0, 99) < 20);
      do_cycle(b, j, lu, ms);
      if ((i % 400 == 399) && (m_flush_left > 0 || m_pend != 0)) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Front-end pipeline controller that sequences the PC-source mux, IF/ID write enables and IF/ID flush strobes. It combines taken-branch, jump, load-use and memory-stall events, replacing the free-running redirect decode with a state machine. The state machine holds a redirect through a memory stall and stretches flushes to a configurable depth. It sits between the EX-stage branch comparator / ID-stage jump decoder and the PC register, PC mux and IF/ID pipeline register.

## Interface
Parameters:
- FLUSH_CYCLES, 1: cycles IF_Flush/ID_Flush stay high per redirect; legal 1..4.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- branch  in  1  taken conditional branch resolved in EX.
- jump  in  2  00 none, 01 jal (PC+imm target), 10 jalr (register target), 11 reserved (treated as none).
- load_use  in  1  ID-stage load-use hazard.
- mem_stall  in  1  memory not ready; freezes front end.
- pc_sel  out  2  00 PC+4, 01 branch/jal target, 10 jalr target.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- IF_Flush  out  1  zero IF/ID contents.
- ID_Flush  out  1  zero ID/EX control.
- redirect_cnt  out  CNT_W  redirects taken.
- stall_cnt  out  CNT_W  cycles with pc_write low.

## Operation
- Redirect event: branch=1, or jump=01/10. Priority: branch > jump; branch with any jump gives pc_sel 01. jump=11 is ignored.
- Target select: branch or jal gives 01; jalr gives 10.
- Reset state: RUN. Outputs: pc_sel 00, IF_Flush 0, ID_Flush 0, counters 0, pend_sel 00, flush counter 0.
- RUN:
  - Redirect with mem_stall=0: register pc_sel, set both flushes, load flush counter with FLUSH_CYCLES-1, go to FLUSH.
  - Redirect with mem_stall=1: latch target into pend_sel, go to PEND. Outputs stay 00/0.
  - No redirect: pc_sel 00, flushes 0.
- FLUSH:
  - pc_sel returns to 00 after the first flush cycle; the PC is redirected exactly once.
  - Flushes stay high while the counter is nonzero. The counter decrements only when mem_stall=0.
  - On the counter reaching 0 with mem_stall=0: flushes drop next cycle, return to RUN.
  - FLUSH_CYCLES=1: FLUSH lasts one cycle.
  - Redirect inputs are ignored in FLUSH; they come from squashed instructions.
- PEND:
  - Outputs 00/0 while mem_stall=1.
  - First cycle mem_stall=0: pc_sel <= pend_sel, flushes set, counter loaded, go to FLUSH.
  - A further redirect while in PEND is ignored; the first latched target wins.
- Stall enables (combinational):
  - pc_write = if_id_write = ~mem_stall & ~(load_use & ~ID_Flush).
  - load_use is masked while ID_Flush=1, because the hazarding instruction is being squashed.
- Asynchronous reset mid-FLUSH or mid-PEND discards the pending target. Outputs drop to reset values immediately.

## Timing
- Redirect sampled at edge N:
  - pc_sel valid during cycle N+1 only.
  - IF_Flush/ID_Flush high for cycles N+1..N+FLUSH_CYCLES, extended by any mem_stall cycles.
- Redirect during stall: redirect at edge N, mem_stall low first sampled at edge M, so pc_sel and flushes are valid in cycle M+1.
- pc_write and if_id_write have zero latency: same cycle as load_use/mem_stall.
- Back-to-back redirects: the next redirect is accepted on the first RUN cycle after FLUSH ends.

## Configuration
- REDIRECT_PERF_EN defined:
  - redirect_cnt increments on every entry to FLUSH.
  - stall_cnt increments on every cycle with pc_write=0 outside reset.
  - Both counters saturate at all ones and reset to 0.
- REDIRECT_PERF_EN undefined: counter logic removed; redirect_cnt and stall_cnt tied to 0.

## Test plan
- Reset: reset_n low mid-FLUSH → all outputs 0 immediately; state is RUN after release.
- Branch: FLUSH_CYCLES=2, branch=1 at edge 10 →
  - pc_sel=01 in cycle 11, 00 in cycle 12.
  - Flushes high in cycles 11–12, low in cycle 13.
  - redirect_cnt=1 with REDIRECT_PERF_EN.
- Priority: branch=1 and jump=10 together → pc_sel=01. jump=11 alone → no flush, pc_sel=00.
- Redirect under stall: jump=10 at edge 5 with mem_stall high during cycles 5–8, second jump=01 at edge 7 →
  - pc_sel=10 and flushes only in cycle 10.
  - Second jump is ignored.
- Load-use: load_use=1, no flush → pc_write=if_id_write=0 in that cycle. load_use=1 during ID_Flush=1 → enables stay 1.
- Stall during flush: FLUSH_CYCLES=3, mem_stall high for 2 cycles mid-flush → flushes high for 5 cycles total; stall_cnt=2.
